// File: rtl/sram_controller.sv
// Memory-stage controller for a 16-bit external async SRAM: each 32-bit CPU
// access is split into a low and a high half-word phase and stalls the pipeline.
module sram_controller #(
  parameter int ADDRESS_LEN = 32,
  parameter int WORD_LEN    = 32,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [ADDRESS_LEN-1:0] address,
  input  logic [WORD_LEN-1:0]    write_data,
  output logic [WORD_LEN-1:0]    read_data,
  output logic                   ready,
  inout  wire  [15:0]            SRAM_DQ,
  output logic [17:0]            SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  localparam logic [3:0]             LAST_CNT = 4'(WAIT_CYCLES);
  localparam logic [ADDRESS_LEN-1:0] BASE     = ADDRESS_LEN'(BASE_ADDR);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_op_q, wr_op_d;
  logic [16:0]         idx_q, idx_d;
  logic [15:0]         wdata_hi_q, wdata_hi_d;
  logic [WORD_LEN-1:0] rdata_q, rdata_d;
  logic [17:0]         sram_addr_q, sram_addr_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic [15:0]         dq_out_q, dq_out_d;

  logic                   req;
  logic [ADDRESS_LEN-1:0] offset;
  logic [16:0]            req_idx;
  logic                   unused_off;

  assign req        = wr_en | rd_en;
  assign offset     = address - BASE;
  assign req_idx    = offset[18:2];
  assign unused_off = ^{offset[1:0], offset[ADDRESS_LEN-1:19]};

  // Outputs are registered, so they are computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_op_d     = wr_op_q;
    idx_d       = idx_q;
    wdata_hi_d  = wdata_hi_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    we_n_d      = we_n_q;
    oe_n_d      = oe_n_q;
    dq_oe_d     = dq_oe_q;
    dq_out_d    = dq_out_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d     = LOW;
          cnt_d       = '0;
          wr_op_d     = wr_en;
          idx_d       = req_idx;
          wdata_hi_d  = write_data[31:16];
          sram_addr_d = {req_idx, 1'b0};
          we_n_d      = ~wr_en;
          oe_n_d      = wr_en;
          dq_oe_d     = wr_en;
          dq_out_d    = write_data[15:0];
        end
      end
      LOW: begin
        if (cnt_q == LAST_CNT) begin
          state_d     = HIGH;
          cnt_d       = '0;
          sram_addr_d = {idx_q, 1'b1};
          dq_out_d    = wdata_hi_q;
          if (!wr_op_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          cnt_d   = '0;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          dq_oe_d = 1'b0;
          if (!wr_op_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_op_q     <= 1'b0;
      idx_q       <= '0;
      wdata_hi_q  <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_op_q     <= wr_op_d;
      idx_q       <= idx_d;
      wdata_hi_q  <= wdata_hi_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign ready     = (state_q == DONE) || ((state_q == IDLE) && !req);
  assign read_data = rdata_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'bz;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit async SRAM model.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n;

  logic [15:0] mem [32];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  sram_controller #(
    .ADDRESS_LEN(32),
    .WORD_LEN(32),
    .BASE_ADDR(1024),
    .WAIT_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .ready(ready),
    .SRAM_DQ(sram_dq),
    .SRAM_ADDR(sram_addr),
    .SRAM_WE_N(sram_we_n),
    .SRAM_OE_N(sram_oe_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[4:0]] : 16'bz;
  always @(posedge clk) if (!sram_we_n) mem[sram_addr[4:0]] <= sram_dq;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [17:0] exp_saddr;
    bit          chk_mem;
    int unsigned lo_idx;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
  endtask

  // Issues a request at the next negedge and returns in the ready=1 cycle.
  task automatic run_req(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output int ctl_bad);
    @(negedge clk);
    wr_en = w; rd_en = r; address = a; write_data = d;
    #1;
    ctl_bad = 0;
    for (lat = 1; lat <= 40; lat++) begin
      if (ready) break;
      if (lat == 1) begin
        if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) ctl_bad++;
      end else if (sram_we_n !== ~w || sram_oe_n !== w) begin
        ctl_bad++;
      end
      @(negedge clk); #1;
    end
    if (lat > 40) lat = -1;
  endtask

  initial begin
    int lat, bad, t1, lat2;
    logic [31:0] rd1;

    for (int i = 0; i < 32; i++) mem[i] = 16'hA500 + 16'(i);

    vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h00000000, 18'h00001, 1'b1, 0,  16'hBEEF, 16'hDEAD};
    vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h0,        32'hDEADBEEF, 18'h00001, 1'b0, 0,  16'h0,    16'h0};
    vecs[2] = '{1'b1, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF, 18'h00003, 1'b1, 2,  16'h5678, 16'h1234};
    vecs[3] = '{1'b0, 1'b1, 32'd1028, 32'h0,        32'h12345678, 18'h00003, 1'b0, 0,  16'h0,    16'h0};
    vecs[4] = '{1'b1, 1'b0, 32'd1030, 32'hCAFEF00D, 32'h12345678, 18'h00003, 1'b1, 2,  16'hF00D, 16'hCAFE};
    vecs[5] = '{1'b0, 1'b1, 32'd1028, 32'h0,        32'hCAFEF00D, 18'h00003, 1'b0, 0,  16'h0,    16'h0};
    vecs[6] = '{1'b0, 1'b1, 32'd1032, 32'h0,        32'hA505A504, 18'h00005, 1'b0, 0,  16'h0,    16'h0};
    vecs[7] = '{1'b1, 1'b0, 32'd1020, 32'h0BAD1DEA, 32'hA505A504, 18'h3FFFF, 1'b1, 30, 16'h1DEA, 16'h0BAD};
    vecs[8] = '{1'b0, 1'b1, 32'd1020, 32'h0,        32'h0BAD1DEA, 18'h3FFFF, 1'b0, 0,  16'h0,    16'h0};
    vecs[9] = '{1'b0, 1'b1, 32'd1027, 32'h0,        32'hDEADBEEF, 18'h00001, 1'b0, 0,  16'h0,    16'h0};

    rst = 1'b0;
    clear_req();
    #12;
    check("rst_ready", ready, 1'b1);
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_oe_n", sram_oe_n, 1'b1);
    check("rst_rdata", read_data, 32'h0);
    check("rst_saddr", sram_addr, 18'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check($sformatf("idle%0d_ready", i), ready, 1'b1);
      check($sformatf("idle%0d_ctl", i), {sram_we_n, sram_oe_n}, 2'b11);
    end

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, lat, bad);
      check($sformatf("v%0d_lat", i), lat, 6);
      check($sformatf("v%0d_ctl", i), bad, 0);
      check($sformatf("v%0d_done_ctl", i), {sram_we_n, sram_oe_n}, 2'b11);
      check($sformatf("v%0d_rdata", i), read_data, vecs[i].exp_rdata);
      check($sformatf("v%0d_saddr", i), sram_addr, vecs[i].exp_saddr);
      if (vecs[i].chk_mem) begin
        check($sformatf("v%0d_mem_lo", i), mem[vecs[i].lo_idx], vecs[i].exp_lo);
        check($sformatf("v%0d_mem_hi", i), mem[vecs[i].lo_idx + 1], vecs[i].exp_hi);
      end
      clear_req();
    end

    // Inputs change while the write is in flight; request held through DONE.
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1036; write_data = 32'h11112222;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; address = 32'd1024; write_data = 32'h0;
    #1;
    for (lat = 2; lat <= 40; lat++) begin
      if (ready) break;
      @(negedge clk); #1;
    end
    if (lat > 40) lat = -1;
    check("chg_lat", lat, 6);
    check("chg_mem_lo", mem[6], 16'h2222);
    check("chg_mem_hi", mem[7], 16'h1111);
    check("chg_rdata", read_data, 32'hDEADBEEF);
    @(negedge clk);
    clear_req();
    #1;
    check("done_no_restart_ready", ready, 1'b1);
    check("done_no_restart_ctl", {sram_we_n, sram_oe_n}, 2'b11);

    // Back-to-back reads: request stays asserted across the DONE edge.
    run_req(1'b0, 1'b1, 32'd1024, 32'h0, lat, bad);
    t1 = cyc; rd1 = read_data;
    run_req(1'b0, 1'b1, 32'd1028, 32'h0, lat2, bad);
    check("b2b_lat1", lat, 6);
    check("b2b_data1", rd1, 32'hDEADBEEF);
    check("b2b_lat2", lat2, 6);
    check("b2b_gap", cyc - t1, 6);
    check("b2b_data2", read_data, 32'hCAFEF00D);
    clear_req();

    // Reset asserted in the second HIGH cycle of a write.
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1040; write_data = 32'h55556666;
    repeat (4) @(negedge clk);
    #1;
    check("midrst_busy", ready, 1'b0);
    check("midrst_we_active", sram_we_n, 1'b0);
    clear_req();
    rst = 1'b0;
    #1;
    check("midrst_ready", ready, 1'b1);
    check("midrst_ctl", {sram_we_n, sram_oe_n}, 2'b11);
    check("midrst_rdata", read_data, 32'h0);
    check("midrst_saddr", sram_addr, 18'h0);
    @(negedge clk);
    rst = 1'b1;
    run_req(1'b0, 1'b1, 32'd1024, 32'h0, lat, bad);
    check("postrst_lat", lat, 6);
    check("postrst_ctl", bad, 0);
    check("postrst_rdata", read_data, 32'hDEADBEEF);
    clear_req();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
